song_sequencer: RTL and testbench
=================================

# song_sequencer

Playback controller for the ROM-song path. Owns the ROM address, the per-note beat counter and a built-in tempo-tick divider, and runs a play/pause/stop/loop state machine that steps the selected song. Sits between the user-control debouncers and the song ROM. Its `playing` output tells the note/pitch output mux when the ROM drives the tone generator instead of the keyboard.

## Interface
- `TICK_DIV_SLOW`, default 12_500_000: clock cycles per beat-tick at normal speed.
- `TICK_DIV_FAST`, default 6_250_000: clock cycles per beat-tick at fast speed.
- `ADDR_W`, default 10: ROM address and song-length width.
- `BEAT_W`, default 4: beat-count width.

Ports:
- `clk` in 1: system clock, single domain.
- `rst` in 1: asynchronous, active-low reset.
- `play` in 1: one-cycle pulse; start or restart playback.
- `pause` in 1: one-cycle pulse; toggle PLAY/PAUSE.
- `stop` in 1: one-cycle pulse; abort to IDLE.
- `cycle` in 1: level; loop the song at its end.
- `autospeed` in 1: level; 1 selects `TICK_DIV_FAST`.
- `songselect` in 3: song index, sampled on `play`.
- `rom_beat` in BEAT_W: beats for the current address (ROM, combinational).
- `rom_len` in ADDR_W: last valid address of the current song (inclusive).
- `rom_song` out 3: latched song index driven to the ROM.
- `rom_addr` out ADDR_W: current note address.
- `playing` out 1: high in PLAY or PAUSE.
- `step` out 1: one-cycle pulse when `rom_addr` advances or wraps.
- `done` out 1: high in DONE.
- `state` out 2: IDLE=0, PLAY=1, PAUSE=2, DONE=3.

## Operation
- Reset: IDLE. `rom_addr`=0, `rom_song`=0, beat count=0, divider=0. `playing`, `step` and `done` are 0.
- Command priority, same cycle: `stop` > `play` > `pause`.
- `stop` in any state: go to IDLE. Clear `rom_addr`, beat count and divider.
- `play` in any state: latch `songselect` into `rom_song`. Clear `rom_addr`, beat count and divider. Go to PLAY. This includes restart from PLAY, PAUSE or DONE.
- `pause`: in PLAY go to PAUSE; in PAUSE go to PLAY. Ignored in IDLE and DONE.
- In PAUSE the divider, beat count and address all hold.
- Divider, PLAY only:
  - Counts 0 to DIV-1, then asserts an internal tick and returns to 0.
  - DIV is chosen by `autospeed`, sampled each cycle.
  - If DIV shrinks below the current count, the tick fires on the next cycle.
- Per tick, with beat limit B = max(`rom_beat`, 1), so a beat of 0 plays as 1:
  - If beat count < B-1: increment it.
  - Otherwise: clear beat count and assert `step`, then:
    - If `rom_addr` < `rom_len`: `rom_addr`+1.
    - Else if `cycle`=1: `rom_addr`=0, stay in PLAY.
    - Else: go to DONE, `rom_addr` holds at `rom_len`.
- `songselect` changes during PLAY or PAUSE have no effect until the next `play`.
- `rom_len`=0: a single-note song. It loops or finishes after B ticks.

## Timing
- All outputs are registered.
- `state`, `playing` and `done` update on the clock edge after the command pulse.
- `rom_addr` and `step` update on the edge after the qualifying tick. `step` is high for exactly that one cycle.
- `rom_beat` and `rom_len` are sampled in the tick cycle and must be valid 1 cycle after `rom_addr` or `rom_song` change.
- From `play` to the first `step`: B×DIV+1 cycles.
- Reset mid-playback takes effect immediately (asynchronous). Release is synchronous to `clk`; the first command is accepted on the cycle after release.

## Configuration
- `SONG_SEQ_PAUSE_EN` defined: PAUSE state and `pause` input behave as specified above.
- Not defined:
  - `pause` is ignored and PAUSE is unreachable.
  - `playing` equals (`state`==PLAY).
  - The `state` encoding is unchanged.

## Structure
- Package `song_seq_pkg` holds:
  - the state enum (IDLE/PLAY/PAUSE/DONE, 2-bit);
  - `ADDR_W` and `BEAT_W` defaults;
  - the song-select width (3).
- Sub-module `beat_tick_gen` is the divider. Inputs: `clk`, `rst`, enable, clear, fast select. Output: one-cycle tick.

## Test plan
Bench settings: `TICK_DIV_SLOW`=4, `TICK_DIV_FAST`=2.
- Play song 2, `rom_beat`=1, `rom_len`=3, `cycle`=0 → `rom_song`=2; `rom_addr` steps 0,1,2,3 with `step` every 4 cycles; after the next tick `done`=1 and `rom_addr` stays 3.
- Same song with `cycle`=1 → after address 3, `rom_addr` wraps to 0, `step` pulses and the sequencer stays in PLAY.
- `rom_beat`=3 → 12 cycles per address; `rom_beat`=0 → 4 cycles per address.
- Pause after 2 steps, hold 50 cycles, pause again → `rom_addr` frozen at 2 throughout and the next `step` arrives exactly at the remaining divider count.
- `stop` and `play` in the same cycle during PLAY → IDLE, `rom_addr`=0, `playing`=0. `autospeed`=1 → `step` period halves to 2 cycles with `rom_beat`=1.
- Drive `rst` low mid-song → all outputs return to reset values immediately; a `play` after release restarts from address 0.

Source files
------------

// File: rtl/song_seq_pkg.sv
// Shared types and defaults for the ROM-song playback sequencer.
//   seq_state_e : 2-bit playback state (IDLE/PLAY/PAUSE/DONE)
//   ADDR_W_DEF  : default ROM address / song-length width
//   BEAT_W_DEF  : default beat-count width
//   SONG_W      : song-select width
package song_seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int ADDR_W_DEF = 10;
  localparam int BEAT_W_DEF = 4;
  localparam int SONG_W     = 3;
endpackage

// File: rtl/song_sequencer_beat_tick_gen.sv
// beat_tick_gen: tempo divider. Counts 0..DIV-1 while enabled and pulses
// `tick` in the cycle the count reaches DIV-1, then restarts from 0.
// DIV is DIV_FAST when `fast` is high, else DIV_SLOW, chosen every cycle;
// a count already past a newly shrunk limit ticks at once.
// Ports: clk, rst (async active-low), en (count), clr (zero count,
// overrides en), fast (divider select), tick (one-cycle pulse).
module beat_tick_gen #(
  parameter int DIV_SLOW = 4,
  parameter int DIV_FAST = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic fast,
  output logic tick
);
  localparam int DMAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CNT_W = (DMAX > 2) ? $clog2(DMAX) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;

  assign lim  = fast ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
  assign tick = en && !clr && (cnt >= lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: play/pause/stop/loop controller for the ROM-song path.
// Owns the ROM address, per-note beat counter and tempo divider.
// Optional feature macro: SONG_SEQ_PAUSE_EN (enables PAUSE / `pause`).
// Ports:
//   clk, rst (async active-low)
//   play/pause/stop : one-cycle command pulses (stop > play > pause)
//   cycle           : loop at song end;  autospeed : fast tempo select
//   songselect      : song index, latched on play
//   rom_beat/rom_len: ROM beat count for rom_addr, last address of song
//   rom_song/rom_addr : ROM lookup outputs
//   playing, step, done, state : status
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int TICK_DIV_SLOW = 12_500_000,
  parameter int TICK_DIV_FAST = 6_250_000,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int BEAT_W        = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              cycle,
  input  logic              autospeed,
  input  logic [SONG_W-1:0] songselect,
  input  logic [BEAT_W-1:0] rom_beat,
  input  logic [ADDR_W-1:0] rom_len,
  output logic [SONG_W-1:0] rom_song,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              playing,
  output logic              step,
  output logic              done,
  output logic [1:0]        state
);
  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              step_q, step_d;
  logic              pause_go, tick, last_beat;
  logic [BEAT_W-1:0] beat_lim;

`ifdef SONG_SEQ_PAUSE_EN
  assign pause_go = pause && !stop && !play &&
                    (state_q == PLAY || state_q == PAUSE);
  assign playing  = (state_q == PLAY) || (state_q == PAUSE);
`else
  assign pause_go = 1'b0;
  assign playing  = (state_q == PLAY);
`endif

  // Divider freezes in the cycle a pause is taken so no tick is lost.
  beat_tick_gen #(
    .DIV_SLOW(TICK_DIV_SLOW),
    .DIV_FAST(TICK_DIV_FAST)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  ((state_q == PLAY) && !pause_go),
    .clr (stop || play),
    .fast(autospeed),
    .tick(tick)
  );

  // A beat value of 0 plays as a single beat.
  assign beat_lim  = (rom_beat == '0) ? BEAT_W'(1) : rom_beat;
  assign last_beat = (beat_q >= beat_lim - 1'b1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    song_d  = song_q;
    beat_d  = beat_q;
    step_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      addr_d  = '0;
      beat_d  = '0;
    end else if (play) begin
      state_d = PLAY;
      song_d  = songselect;
      addr_d  = '0;
      beat_d  = '0;
    end else if (pause_go) begin
      state_d = (state_q == PLAY) ? PAUSE : PLAY;
    end else if (tick) begin
      if (!last_beat) begin
        beat_d = beat_q + 1'b1;
      end else begin
        beat_d = '0;
        step_d = 1'b1;
        if (addr_q < rom_len) addr_d = addr_q + 1'b1;
        else if (cycle)       addr_d = '0;
        else                  state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      song_q  <= '0;
      beat_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      song_q  <= song_d;
      beat_q  <= beat_d;
      step_q  <= step_d;
    end
  end

  assign rom_song = song_q;
  assign rom_addr = addr_q;
  assign step     = step_q;
  assign done     = (state_q == DONE);
  assign state    = state_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios then random commands, all
// checked against a cycle-level reference model and a step scoreboard.
module tb_song_sequencer;
  import song_seq_pkg::*;

  localparam int SLOW = 4;
  localparam int FAST = 2;
  localparam int AW   = 10;
  localparam int BW   = 4;
`ifdef SONG_SEQ_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0;
  logic          play = 1'b0, pause = 1'b0, stop = 1'b0;
  logic          cycle = 1'b0, autospeed = 1'b0;
  logic [2:0]    songselect = '0;
  logic [BW-1:0] rom_beat;
  logic [AW-1:0] rom_len;
  logic [2:0]    rom_song;
  logic [AW-1:0] rom_addr;
  logic          playing, step, done;
  logic [1:0]    state;

  song_sequencer #(
    .TICK_DIV_SLOW(SLOW), .TICK_DIV_FAST(FAST), .ADDR_W(AW), .BEAT_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .cycle(cycle), .autospeed(autospeed), .songselect(songselect),
    .rom_beat(rom_beat), .rom_len(rom_len), .rom_song(rom_song),
    .rom_addr(rom_addr), .playing(playing), .step(step), .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  // Song ROM: fixed values for directed tests, a per-song table for random.
  int rom_mode = 0, fix_beat = 1, fix_len = 3;
  function automatic int f_beat(input int s, input int a);
    return rom_mode != 0 ? ((s * 5 + a * 3) % 4) : fix_beat;
  endfunction
  function automatic int f_len(input int s);
    return rom_mode != 0 ? (s % 4) : fix_len;
  endfunction
  always_comb begin
    rom_beat = BW'(f_beat(int'(rom_song), int'(rom_addr)));
    rom_len  = AW'(f_len(int'(rom_song)));
  end

  int checks = 0, errors = 0;
  longint cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: "elapsed" is cycles spent playing since the last tick;
  // a tick is due once elapsed+1 reaches the divider currently selected.
  typedef struct { int addr; int st; longint t; } step_t;
  step_t sbq[$];
  int m_state = 0, m_addr = 0, m_song = 0, m_beat = 0, m_el = 0;
  bit m_step = 1'b0;

  initial forever begin
    int dv, bl;
    bit pz;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_state = 0; m_addr = 0; m_song = 0; m_beat = 0; m_el = 0;
      m_step = 0;
      sbq.delete();
    end else begin
      cyc++;
      m_step = 0;
      dv = autospeed ? FAST : SLOW;
      pz = PEN && pause && (m_state == 1 || m_state == 2);
      if (stop) begin
        m_state = 0; m_addr = 0; m_beat = 0; m_el = 0;
      end else if (play) begin
        m_state = 1; m_song = int'(songselect); m_addr = 0; m_beat = 0; m_el = 0;
      end else if (pz) begin
        m_state = (m_state == 1) ? 2 : 1;
      end else if (m_state == 1) begin
        if (m_el + 1 >= dv) begin
          m_el = 0;
          bl = f_beat(m_song, m_addr);
          if (bl == 0) bl = 1;
          if (m_beat + 1 < bl) m_beat++;
          else begin
            m_beat = 0;
            m_step = 1;
            if (m_addr < f_len(m_song)) m_addr++;
            else if (cycle) m_addr = 0;
            else m_state = 3;
            sbq.push_back('{addr: m_addr, st: m_state, t: cyc});
          end
        end else m_el++;
      end
    end
  end

  // Monitor: compare every cycle, and pop the scoreboard on each step.
  initial forever begin
    step_t e;
    @(negedge clk);
    if (rst) begin
      chk("state", state, m_state);
      chk("rom_addr", rom_addr, m_addr);
      chk("rom_song", rom_song, m_song);
      chk("step", step, m_step);
      chk("playing", playing, PEN ? (m_state == 1 || m_state == 2) : (m_state == 1));
      chk("done", done, m_state == 3);
      if (step) begin
        chk("sb_has_entry", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sb_step_addr", rom_addr, e.addr);
          chk("sb_step_state", state, e.st);
          chk("sb_step_time", cyc, e.t);
        end
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_play(input int s);
    songselect = 3'(s); play = 1'b1; clk_n(1); play = 1'b0;
  endtask
  task automatic do_pause();
    pause = 1'b1; clk_n(1); pause = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_addr", rom_addr, 0);
    chk("rst_state", state, 0);
    chk("rst_playing", playing, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1; rst = 1'b1;
    clk_n(1);

    // Song 2, single beats, length 3, no loop: ends in DONE at address 3.
    do_play(2);
    clk_n(20);
    chk("d1_done", done, 1);
    chk("d1_addr", rom_addr, 3);
    chk("d1_song", rom_song, 2);

    // Looping song stays in PLAY.
    cycle = 1'b1;
    do_play(2);
    clk_n(30);
    chk("d2_looping", state, 1);
    cycle = 1'b0;

    fix_beat = 3; do_play(1); clk_n(60);
    fix_beat = 0; do_play(3); clk_n(25);
    fix_beat = 1;

    // Pause after two steps (addr 2 from cycle 9), hold, resume.
    do_play(2);
    clk_n(9);
    if (PEN) begin
      do_pause();
      clk_n(50);
      chk("pz_frozen_addr", rom_addr, 2);
      chk("pz_state", state, 2);
      do_pause();
    end
    clk_n(20);

    // stop and play together: stop wins.
    do_play(4);
    clk_n(6);
    play = 1'b1; stop = 1'b1; clk_n(1); play = 1'b0; stop = 1'b0;
    chk("sp_state", state, 0);
    chk("sp_addr", rom_addr, 0);
    chk("sp_playing", playing, 0);

    autospeed = 1'b1; do_play(5); clk_n(14); autospeed = 1'b0;

    // Asynchronous reset mid-song.
    do_play(6);
    clk_n(7);
    #2 rst = 1'b0;
    #1;
    chk("ar_addr", rom_addr, 0);
    chk("ar_song", rom_song, 0);
    chk("ar_state", state, 0);
    chk("ar_step", step, 0);
    @(posedge clk); #1; rst = 1'b1;
    clk_n(1);
    do_play(2);
    clk_n(20);

    // Random commands against the table ROM.
    rom_mode = 1;
    do_play(3);
    for (int i = 0; i < 3000; i++) begin
      play  = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 99) == 0);
      pause = ($urandom_range(0, 29) == 0);
      songselect = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) cycle = ~cycle;
      if ($urandom_range(0, 29) == 0) autospeed = ~autospeed;
      clk_n(1);
    end
    play = 1'b0; stop = 1'b0; pause = 1'b0;
    clk_n(30);
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
